hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. Sits beside the operand-forwarding unit and covers the hazards forwarding cannot resolve: load-use stalls, taken-branch flushes, and holding the pipe while a multi-cycle multiply occupies EX. It drives the stall, bubble and flush enables of the PC, IF/ID, ID/EX and EX/MEM registers, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_chk.sv | 16 +
 rtl/hazard_ctrl_loaduse_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states, register
// address width and the NOP encoding loaded by the bubble and flush paths.
package hazard_ctrl_pkg;

    localparam int REG_W = 4;

    // addi x0, x0, 0: the canonical NOP inserted when a stage is bubbled or flushed
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MULWAIT = 1'b1
    } hcState_e;

    // MULWAIT countdown start: the entry cycle and the mul_done cycle are not counted
    function automatic logic [3:0] mulWaitLoad(input int mulLat);
        return 4'(mulLat - 2);
    endfunction

endpackage

// File: rtl/hazard_ctrl_chk.sv
// Protocol checks for the hazard controller inputs.
module hazard_ctrl_chk
(
    input logic clk,
    input logic rst_n,
    input logic inRun,
    input logic ex_branchTaken,
    input logic ex_isMul
);

    // A taken branch and a multiply cannot both occupy EX while the pipe is running
    branchWithMul_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(inRun && ex_branchTaken && ex_isMul))
        else $error("hazard_ctrl: ex_branchTaken asserted together with ex_isMul");

endmodule

// File: rtl/hazard_ctrl_loaduse_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of a
// load still sitting in EX. Purely combinational so decoder checks can reuse it.
module loaduse_detect
#(
    parameter int REG_W = hazard_ctrl_pkg::REG_W
)
(
    input  logic [REG_W-1:0] id_Rs,
    input  logic [REG_W-1:0] id_Rt,
    input  logic             id_usesRs,
    input  logic             id_usesRt,
    input  logic [REG_W-1:0] id_exRd,
    input  logic             id_exMemRd,
    input  logic             id_exRegWr,
    output logic             lu
);

    // r0 is never written, so a load targeting it can never create a dependency
    assign lu = id_exMemRd & id_exRegWr & (|id_exRd)
              & ((id_usesRs & (id_Rs == id_exRd)) | (id_usesRt & (id_Rt == id_exRd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle multiply holds, plus a saturating stall-cycle counter.
module hazard_ctrl
#(
    parameter int REG_W   = hazard_ctrl_pkg::REG_W,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_Rs,
    input  logic [REG_W-1:0] id_Rt,
    input  logic             id_usesRs,
    input  logic             id_usesRt,
    input  logic [REG_W-1:0] id_exRd,
    input  logic             id_exMemRd,
    input  logic             id_exRegWr,
    input  logic             ex_isMul,
    input  logic             ex_branchTaken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             mul_start,
    output logic             mul_done,
    output logic [CNT_W-1:0] stall_cnt
);
    import hazard_ctrl_pkg::*;

    hcState_e         state_r;
    hcState_e         nextState_s;
    logic [3:0]       cnt_r;
    logic [3:0]       nextCnt_s;
    logic [CNT_W-1:0] stallCnt_r;
    logic             lu_s;

    loaduse_detect #(.REG_W(REG_W)) uLoadUse (
        .id_Rs      (id_Rs),
        .id_Rt      (id_Rt),
        .id_usesRs  (id_usesRs),
        .id_usesRt  (id_usesRt),
        .id_exRd    (id_exRd),
        .id_exMemRd (id_exMemRd),
        .id_exRegWr (id_exRegWr),
        .lu         (lu_s)
    );

    hazard_ctrl_chk uChk (
        .clk            (clk),
        .rst_n          (rst_n),
        .inRun          (state_r == RUN),
        .ex_branchTaken (ex_branchTaken),
        .ex_isMul       (ex_isMul)
    );

    // Control decode and next-state logic; outputs are held low throughout reset
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mul_start     = 1'b0;
        mul_done      = 1'b0;
        nextState_s   = state_r;
        nextCnt_s     = cnt_r;
        if (!rst_n) begin
            nextState_s = RUN;
            nextCnt_s   = 4'd0;
        end else begin
            case (state_r)
                RUN: begin
                    if (ex_branchTaken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (ex_isMul) begin
                        mul_start     = 1'b1;
                        pc_stall      = 1'b1;
                        if_id_stall   = 1'b1;
                        id_ex_stall   = 1'b1;
                        ex_mem_bubble = 1'b1;
                        nextState_s   = MULWAIT;
                        nextCnt_s     = mulWaitLoad(MUL_LAT);
                    end else if (lu_s) begin
                        // one bubble suffices: next cycle the load is in MEM and forwards
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else begin
                        nextState_s = RUN;
                    end
                end
                MULWAIT: begin
                    if (cnt_r != 4'd0) begin
                        pc_stall      = 1'b1;
                        if_id_stall   = 1'b1;
                        id_ex_stall   = 1'b1;
                        ex_mem_bubble = 1'b1;
                        nextCnt_s     = cnt_r - 4'd1;
                    end else begin
                        mul_done    = 1'b1;
                        nextState_s = RUN;
                    end
                end
                default: begin
                    nextState_s = RUN;
                    nextCnt_s   = 4'd0;
                end
            endcase
        end
    end

    // FSM state, multiply countdown and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN;
            cnt_r      <= 4'd0;
            stallCnt_r <= '0;
        end else begin
            state_r <= nextState_s;
            cnt_r   <= nextCnt_s;
            if (pc_stall && (stallCnt_r != {CNT_W{1'b1}})) begin
                stallCnt_r <= stallCnt_r + CNT_W'(1);
            end else begin
                stallCnt_r <= stallCnt_r;
            end
        end
    end

    assign stall_cnt = stallCnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a MUL_LAT=4 instance takes the full
// directed sequence, a MUL_LAT=2 instance checks the shortest multiply.
module tb_hazard_ctrl;

    localparam logic [7:0] C_IDLE = 8'h00;
    localparam logic [7:0] C_LU   = 8'hC8;  // pc, if/id stall, id/ex bubble
    localparam logic [7:0] C_BR   = 8'h28;  // if/id flush, id/ex bubble
    localparam logic [7:0] C_MS   = 8'hD6;  // mul_start plus the four multiply holds
    localparam logic [7:0] C_MW   = 8'hD4;  // multiply holds only
    localparam logic [7:0] C_MD   = 8'h01;  // mul_done

    typedef struct {
        string       nm;
        logic [7:0]  ctrl;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] rs, rt, exRd;
    logic usesRs, usesRt, exMemRd, exRegWr, isMul, br;
    logic isMulB;
    logic [3:0] zero4 = 4'd0;
    logic zero1 = 1'b0;

    logic pcA, ifsA, iffA, idsA, idbA, exbA, msA, mdA;
    logic pcB, ifsB, iffB, idsB, idbB, exbB, msB, mdB;
    logic [15:0] cntA, cntB;

    exp_t qA[$];
    exp_t qB[$];
    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(4), .MUL_LAT(4), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n),
        .id_Rs(rs), .id_Rt(rt), .id_usesRs(usesRs), .id_usesRt(usesRt),
        .id_exRd(exRd), .id_exMemRd(exMemRd), .id_exRegWr(exRegWr),
        .ex_isMul(isMul), .ex_branchTaken(br),
        .pc_stall(pcA), .if_id_stall(ifsA), .if_id_flush(iffA), .id_ex_stall(idsA),
        .id_ex_bubble(idbA), .ex_mem_bubble(exbA), .mul_start(msA), .mul_done(mdA),
        .stall_cnt(cntA)
    );

    hazard_ctrl #(.REG_W(4), .MUL_LAT(2), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n),
        .id_Rs(zero4), .id_Rt(zero4), .id_usesRs(zero1), .id_usesRt(zero1),
        .id_exRd(zero4), .id_exMemRd(zero1), .id_exRegWr(zero1),
        .ex_isMul(isMulB), .ex_branchTaken(zero1),
        .pc_stall(pcB), .if_id_stall(ifsB), .if_id_flush(iffB), .id_ex_stall(idsB),
        .id_ex_bubble(idbB), .ex_mem_bubble(exbB), .mul_start(msB), .mul_done(mdB),
        .stall_cnt(cntB)
    );

    task automatic compare(input string who, input exp_t e, input logic [7:0] ctrl, input logic [15:0] cnt);
        nVec++;
        if (ctrl !== e.ctrl) begin
            nMis++;
            $display("FAIL %s_%s ctrl: got %b expected %b", who, e.nm, ctrl, e.ctrl);
        end
        nVec++;
        if (cnt !== e.cnt) begin
            nMis++;
            $display("FAIL %s_%s stall_cnt: got %0d expected %0d", who, e.nm, cnt, e.cnt);
        end
    endtask

    // Monitor: compares any pending expectation against the outputs mid-cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (qA.size() > 0) begin
            e = qA.pop_front();
            compare("A", e, {pcA, ifsA, iffA, idsA, idbA, exbA, msA, mdA}, cntA);
        end
        if (qB.size() > 0) begin
            e = qB.pop_front();
            compare("B", e, {pcB, ifsB, iffB, idsB, idbB, exbB, msB, mdB}, cntB);
        end
    end

    task automatic expA(input string nm, input logic [7:0] ctrl, input logic [15:0] cnt);
        exp_t e;
        e.nm = nm; e.ctrl = ctrl; e.cnt = cnt;
        qA.push_back(e);
    endtask

    task automatic expB(input string nm, input logic [7:0] ctrl, input logic [15:0] cnt);
        exp_t e;
        e.nm = nm; e.ctrl = ctrl; e.cnt = cnt;
        qB.push_back(e);
    endtask

    task automatic drive(input logic [3:0] rd, input logic mem, input logic wr,
                         input logic [3:0] s, input logic us, input logic [3:0] t, input logic ut,
                         input logic mul, input logic b);
        exRd = rd; exMemRd = mem; exRegWr = wr;
        rs = s; usesRs = us; rt = t; usesRt = ut;
        isMul = mul; br = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        isMulB = 1'b1;
        drive(4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        expA("rst_lu", C_IDLE, 16'd0); expB("rst_mul", C_IDLE, 16'd0); tick();

        rst_n = 1'b1; isMulB = 1'b0;
        expA("lu_rs", C_LU, 16'd0); expB("idle", C_IDLE, 16'd0); tick();
        drive(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        expA("idle", C_IDLE, 16'd1); tick();
        drive(4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        expA("lu_r0", C_IDLE, 16'd1); tick();
        drive(4'd5, 1'b1, 1'b1, 4'd3, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        expA("lu_rt", C_LU, 16'd1); tick();
        drive(4'd5, 1'b1, 1'b0, 4'd3, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        expA("lu_nowr", C_IDLE, 16'd2); tick();
        drive(4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        expA("br_lu", C_BR, 16'd2); tick();
        drive(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        expA("post_br", C_IDLE, 16'd2); tick();

        // Back-to-back multiplies; hazards raised during MULWAIT must be ignored
        isMul = 1'b1;
        expA("mul1_start", C_MS, 16'd2); tick();
        drive(4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        expA("mul1_w1", C_MW, 16'd3); tick();
        drive(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        expA("mul1_w2", C_MW, 16'd4); tick();
        br = 1'b0;
        expA("mul1_done", C_MD, 16'd5); tick();
        expA("mul2_start", C_MS, 16'd5); tick();
        expA("mul2_w1", C_MW, 16'd6); tick();
        expA("mul2_w2", C_MW, 16'd7); tick();
        expA("mul2_done", C_MD, 16'd8); tick();
        isMul = 1'b0;
        expA("post_mul", C_IDLE, 16'd8); tick();

        // Reset one cycle into a multiply
        isMul = 1'b1;
        expA("mul3_start", C_MS, 16'd8); tick();
        isMul = 1'b0; rst_n = 1'b0;
        expA("rst_mid", C_IDLE, 16'd0); tick();
        rst_n = 1'b1;
        expA("rel1", C_IDLE, 16'd0); tick();
        expA("rel2", C_IDLE, 16'd0); tick();
        expA("rel3", C_IDLE, 16'd0); tick();

        // Shortest multiply on the MUL_LAT=2 instance
        isMulB = 1'b1;
        expB("mul_start", C_MS, 16'd0); tick();
        isMulB = 1'b0;
        expB("mul_done", C_MD, 16'd1); tick();
        expB("post_mul", C_IDLE, 16'd1); tick();

        // Hold a load-use hit long enough to saturate the counter
        drive(4'd7, 1'b1, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (65541) @(posedge clk);
        #1;
        expA("sat", C_LU, 16'hFFFF); tick();
        drive(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        expA("sat_hold", C_IDLE, 16'hFFFF); tick();

        if (qA.size() + qB.size() != 0) begin
            nMis++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", qA.size() + qB.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
